// File: rtl/bg_scroll_renderer.sv
// bg_scroll_renderer
// Background layer for the VGA pipeline. Maps the current screen coordinate to
// an address in an external synchronous index ROM, with power-of-2 upscaling
// and wrap-around scrolling. The returned index goes through an external
// combinational palette, and the result is registered as the pixel colour. The
// colour stays aligned to a delayed copy of blank.
//
// Ports
//   vga_clk, reset_n            pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank         screen coordinate and display enable (1 = active)
//   frame_start                 one-cycle pulse; copies shadow scroll -> active scroll
//   scroll_we, scroll_x/y       shadow scroll write (out-of-range writes rejected)
//   rom_address / rom_q         index ROM address (registered) and data (ROM_LAT later)
//   pal_index / pal_red/green/blue   combinational palette lookup
//   red, green, blue, pix_trans registered pixel colour and transparency flag
//   scroll_err                  sticky flag: a scroll write was rejected
//
// Latency from DrawX/DrawY/blank to red/green/blue is ROM_LAT+2 cycles.
module bg_scroll_renderer #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int SCALE_SH  = 0,
    parameter int ADDR_W    = 19,
    parameter int IDX_W     = 4,
    parameter int COLOR_W   = 4,
    parameter int ROM_LAT   = 1,
    parameter int TRANS_IDX = 0
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic               scroll_we,
    input  logic [9:0]         scroll_x,
    input  logic [9:0]         scroll_y,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [COLOR_W-1:0] pal_red,
    input  logic [COLOR_W-1:0] pal_green,
    input  logic [COLOR_W-1:0] pal_blue,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               pix_trans,
    output logic               scroll_err
);

    // The address arithmetic needs at least 20 bits (1023*1023 < 2**20).
    localparam int               CALC_W  = (ADDR_W > 20) ? ADDR_W : 20;
    localparam logic [10:0]      W11     = 11'(IMG_W);
    localparam logic [10:0]      H11     = 11'(IMG_H);
    localparam logic [IDX_W-1:0] TRANS_V = IDX_W'(TRANS_IDX);

    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_bad_addr_w
        $error("bg_scroll_renderer: ADDR_W too small for IMG_W*IMG_H");
    end
    if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
        $error("bg_scroll_renderer: ROM_LAT must be 1..3");
    end
    if (SCALE_SH < 0 || SCALE_SH > 3) begin : g_bad_scale
        $error("bg_scroll_renderer: SCALE_SH must be 0..3");
    end

    // Scroll registers: the shadow copy is written at any time, and the active
    // copy changes only on frame_start.
    logic [9:0] shadow_x, shadow_y;
    logic [9:0] act_x, act_y;

    // NOTE: every register in this module uses non-blocking assignment, so
    // that frame_start and scroll_we in the same cycle copy the OLD shadow
    // value into active.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x   <= '0;
            shadow_y   <= '0;
            act_x      <= '0;
            act_y      <= '0;
            scroll_err <= 1'b0;
        end else begin
            if (frame_start) begin
                act_x <= shadow_x;
                act_y <= shadow_y;
            end
            if (scroll_we) begin
                if (({1'b0, scroll_x} < W11) && ({1'b0, scroll_y} < H11)) begin
                    shadow_x <= scroll_x;
                    shadow_y <= scroll_y;
                end else begin
                    scroll_err <= 1'b1;
                end
            end
        end
    end

    // Stage 0: scaled coordinate, range check, wrapped source coordinate.
    logic [9:0]        sx, sy;
    logic [10:0]       sum_x, sum_y, wx, wy;
    logic              oob;
    logic [CALC_W-1:0] addr_full;

    // NOTE: this block assigns every signal on every path, so no latch is
    // inferred.
    always_comb begin
        sx    = DrawX >> SCALE_SH;
        sy    = DrawY >> SCALE_SH;
        oob   = ({1'b0, sx} >= W11) || ({1'b0, sy} >= H11);
        sum_x = {1'b0, sx} + {1'b0, act_x};
        sum_y = {1'b0, sy} + {1'b0, act_y};
        // Both terms are below the image size, so one subtract gives the wrap.
        wx    = (sum_x >= W11) ? (sum_x - W11) : sum_x;
        wy    = (sum_y >= H11) ? (sum_y - H11) : sum_y;
        addr_full = CALC_W'(wy) * CALC_W'(IMG_W) + CALC_W'(wx);
    end

    // The blank and oob delay lines run in step with the ROM access. Bit 0 is
    // loaded together with rom_address, and bit ROM_LAT lines up with rom_q.
    logic [ROM_LAT:0] blank_pipe, oob_pipe;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            blank_pipe  <= '0;
            oob_pipe    <= '0;
        end else begin
            rom_address <= oob ? '0 : addr_full[ADDR_W-1:0];
            blank_pipe  <= {blank_pipe[ROM_LAT-1:0], blank};
            oob_pipe    <= {oob_pipe[ROM_LAT-1:0], oob};
        end
    end

    assign pal_index = rom_q;

    // Output stage. Blanked pixels are black and opaque. Pixels outside the
    // image are black and transparent.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_trans <= 1'b0;
        end else if (!blank_pipe[ROM_LAT]) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_trans <= 1'b0;
        end else if (oob_pipe[ROM_LAT]) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_trans <= 1'b1;
        end else begin
            red       <= pal_red;
            green     <= pal_green;
            blue      <= pal_blue;
            pix_trans <= (rom_q == TRANS_V);
        end
    end

endmodule

// File: tb/tb_bg_scroll_renderer.sv
// Testbench for bg_scroll_renderer. The bench uses three instances that share
// the same stimulus:
//   a: 640x480, SCALE_SH=0, ROM_LAT=1
//   b: 320x240, SCALE_SH=1, ROM_LAT=1
//   c: 640x480, SCALE_SH=0, ROM_LAT=3
// ROM word at address n is n[3:0] ^ n[7:4]. The palette maps index i to
// red=i, green=~i, blue=i+3.
module tb_bg_scroll_renderer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] draw_x, draw_y;
    logic       blank, frame_start, scroll_we;
    logic [9:0] scroll_x, scroll_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_f(input logic [19:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    // Instance a
    logic [18:0] addr_a;
    logic [3:0]  rom_q_a, idx_a, pr_a, pg_a, pb_a, red_a, green_a, blue_a;
    logic        trans_a, err_a;
    always @(posedge clk) rom_q_a <= rom_f({1'b0, addr_a});
    assign pr_a = idx_a;
    assign pg_a = ~idx_a;
    assign pb_a = idx_a + 4'd3;

    bg_scroll_renderer #(.IMG_W(640), .IMG_H(480), .SCALE_SH(0), .ADDR_W(19), .ROM_LAT(1)) u_a (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .frame_start(frame_start), .scroll_we(scroll_we), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .rom_address(addr_a), .rom_q(rom_q_a), .pal_index(idx_a),
        .pal_red(pr_a), .pal_green(pg_a), .pal_blue(pb_a),
        .red(red_a), .green(green_a), .blue(blue_a), .pix_trans(trans_a), .scroll_err(err_a));

    // Instance b
    logic [16:0] addr_b;
    logic [3:0]  rom_q_b, idx_b, pr_b, pg_b, pb_b, red_b, green_b, blue_b;
    logic        trans_b, err_b;
    always @(posedge clk) rom_q_b <= rom_f({3'b0, addr_b});
    assign pr_b = idx_b;
    assign pg_b = ~idx_b;
    assign pb_b = idx_b + 4'd3;

    bg_scroll_renderer #(.IMG_W(320), .IMG_H(240), .SCALE_SH(1), .ADDR_W(17), .ROM_LAT(1)) u_b (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .frame_start(frame_start), .scroll_we(scroll_we), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .rom_address(addr_b), .rom_q(rom_q_b), .pal_index(idx_b),
        .pal_red(pr_b), .pal_green(pg_b), .pal_blue(pb_b),
        .red(red_b), .green(green_b), .blue(blue_b), .pix_trans(trans_b), .scroll_err(err_b));

    // Instance c
    logic [18:0] addr_c;
    logic [3:0]  rom_c1, rom_c2, rom_q_c, idx_c, pr_c, pg_c, pb_c, red_c, green_c, blue_c;
    logic        trans_c, err_c;
    always @(posedge clk) begin
        rom_c1  <= rom_f({1'b0, addr_c});
        rom_c2  <= rom_c1;
        rom_q_c <= rom_c2;
    end
    assign pr_c = idx_c;
    assign pg_c = ~idx_c;
    assign pb_c = idx_c + 4'd3;

    bg_scroll_renderer #(.IMG_W(640), .IMG_H(480), .SCALE_SH(0), .ADDR_W(19), .ROM_LAT(3)) u_c (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .frame_start(frame_start), .scroll_we(scroll_we), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .rom_address(addr_c), .rom_q(rom_q_c), .pal_index(idx_c),
        .pal_red(pr_c), .pal_green(pg_c), .pal_blue(pb_c),
        .red(red_c), .green(green_c), .blue(blue_c), .pix_trans(trans_c), .scroll_err(err_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge(s): inputs change and outputs
    // are sampled here, away from the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic write_scroll(input logic [9:0] x, input logic [9:0] y);
        scroll_x  = x;
        scroll_y  = y;
        scroll_we = 1'b1;
        step(1);
        scroll_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; blank = 1'b1; draw_x = 10'd123; draw_y = 10'd77;
        frame_start = 1'b0; scroll_we = 1'b0; scroll_x = '0; scroll_y = '0;
        step(3);
        check("reset addr_a", 32'(addr_a), 0);
        check("reset red_a", 32'(red_a), 0);
        check("reset trans_a", 32'(trans_a), 0);
        check("reset err_a", 32'(err_a), 0);
        check("reset red_c", 32'(red_c), 0);

        // Identity map: (5,2) -> 2*640+5 = 1285, ROM word 5.
        draw_x = 10'd5; draw_y = 10'd2; reset_n = 1'b1;
        step(1);
        check("ident addr_a", 32'(addr_a), 1285);
        step(1);
        check("ident red_a not early", 32'(red_a), 0);
        step(1);
        check("ident red_a", 32'(red_a), 5);
        check("ident green_a", 32'(green_a), 10);
        check("ident blue_a", 32'(blue_a), 8);
        check("ident trans_a", 32'(trans_a), 0);

        // Transparent word: address 17 holds 1^1 = 0.
        draw_x = 10'd17; draw_y = 10'd0;
        step(1);
        check("trans addr_a", 32'(addr_a), 17);
        step(2);
        check("trans flag_a", 32'(trans_a), 1);
        check("trans red_a", 32'(red_a), 0);
        check("trans green_a", 32'(green_a), 15);
        check("trans blue_a", 32'(blue_a), 3);

        // Scale by 2: DrawX=639 -> sx=319, ROM word 0xF^0x3 = 12.
        draw_x = 10'd639; draw_y = 10'd0;
        step(1);
        check("scale addr_b", 32'(addr_b), 319);
        step(2);
        check("scale red_b", 32'(red_b), 12);
        check("scale trans_b", 32'(trans_b), 0);
        // DrawX=640 -> sx=320, outside the image.
        draw_x = 10'd640;
        step(3);
        check("oob addr_b", 32'(addr_b), 0);
        check("oob red_b", 32'(red_b), 0);
        check("oob trans_b", 32'(trans_b), 1);
        // DrawY=479 -> sy=239 -> 239*320 = 76480.
        draw_x = 10'd0; draw_y = 10'd479;
        step(1);
        check("scale addr_b y", 32'(addr_b), 76480);

        // Blank forces black and opaque, even on a transparent word.
        draw_x = 10'd17; draw_y = 10'd0; blank = 1'b0;
        step(3);
        check("blank red_a", 32'(red_a), 0);
        check("blank green_a", 32'(green_a), 0);
        check("blank trans_a", 32'(trans_a), 0);

        // Single active pixel: it appears at +3 on a and at +5 only on c.
        step(6);
        draw_x = 10'd5; draw_y = 10'd2; blank = 1'b1;
        step(1);
        blank = 1'b0; draw_x = 10'd17;
        step(2);
        check("align red_a +3", 32'(red_a), 5);
        step(1);
        check("align red_c +4", 32'(red_c), 0);
        step(1);
        check("align red_c +5", 32'(red_c), 5);
        check("align green_c +5", 32'(green_c), 10);
        step(1);
        check("align red_c +6", 32'(red_c), 0);
        check("align trans_c +6", 32'(trans_c), 0);

        // A scroll write takes effect only at frame_start.
        blank = 1'b1; draw_x = 10'd50; draw_y = 10'd15;
        write_scroll(10'd600, 10'd470);
        step(1);
        check("scroll pending addr_a", 32'(addr_a), 9650);
        check("scroll b rejected err_b", 32'(err_b), 1);
        check("scroll a accepted err_a", 32'(err_a), 0);
        pulse_frame();
        step(1);
        // wx=650-640=10, wy=485-480=5 -> 5*640+10 = 3210; ROM word 0xA^0x8 = 2.
        check("wrap addr_a", 32'(addr_a), 3210);
        check("wrap addr_c", 32'(addr_c), 3210);
        step(2);
        check("wrap red_a", 32'(red_a), 2);

        // A mid-frame write is not used until the next frame.
        write_scroll(10'd100, 10'd0);
        step(1);
        check("midframe addr_a", 32'(addr_a), 3210);
        // Write together with frame_start: active takes the old shadow (100,0).
        scroll_x = 10'd200; scroll_y = 10'd0; scroll_we = 1'b1; frame_start = 1'b1;
        step(1);
        scroll_we = 1'b0; frame_start = 1'b0;
        step(1);
        check("same cycle old addr_a", 32'(addr_a), 9750);
        pulse_frame();
        step(1);
        check("next frame addr_a", 32'(addr_a), 9850);

        // An out-of-range write is ignored, and the error flag stays set.
        write_scroll(10'd640, 10'd0);
        check("bad write err_a", 32'(err_a), 1);
        pulse_frame();
        step(1);
        check("bad write ignored addr_a", 32'(addr_a), 9850);
        step(5);
        check("err sticky err_a", 32'(err_a), 1);

        // Reset asserted mid-line flushes the pipe and clears the scroll state.
        draw_x = 10'd5; draw_y = 10'd2;
        step(1);
        reset_n = 1'b0;
        step(1);
        check("midreset addr_a", 32'(addr_a), 0);
        check("midreset red_a", 32'(red_a), 0);
        check("midreset err_a", 32'(err_a), 0);
        reset_n = 1'b1;
        step(1);
        check("post reset addr_a", 32'(addr_a), 1285);
        step(1);
        check("post reset red_a +2", 32'(red_a), 0);
        step(1);
        check("post reset red_a +3", 32'(red_a), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
